screen_sequencer: RTL
=====================

// Module: screen_sequencer
// PURPOSE
//  Top-level screen controller for the TicTacToe VGA path. Sequences START -> PLAY -> WINNER screens,
//  grants the single shared font ROM address port to the active text generator, and gates that
//  generator's ce. Screen changes take effect only at a frame boundary, so no frame shows two screens.
//  Sits between the VGA sync block and the start/board/winner text generators and the font ROM.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  V_ACTIVE    480  visible lines per frame
//  WIN_FRAMES  180  minimum frames the WINNER screen is held (~3 s at 60 Hz); must be >= 1
//  FCNT_W      8    frame counter width; 2**FCNT_W > WIN_FRAMES
// PORTS
//  clk              in   1   system clock
//  reset_n          in   1   asynchronous active-low reset
//  pixel_tick       in   1   pixel-rate enable from vga sync
//  video_on         in   1   active-video flag
//  pix_x, pix_y     in   10  current pixel coordinates
//  start_btn        in   1   raw start button, asynchronous, active-high
//  game_over        in   1   level from game logic: board finished
//  winner_in        in   2   00 none, 01 X, 10 O, 11 draw; valid while game_over=1
//  start_rom_addr   in   11  font address requested by start screen
//  board_rom_addr   in   11  font address requested by board screen
//  win_rom_addr     in   11  font address requested by winner screen
//  start_rgb, board_rgb, win_rgb  in  3  per-generator pixel colour
//  rom_addr         out  11  address to the shared font ROM
//  ce_start, ce_board, ce_win  out  1  one-hot generator enables
//  winner_sel       out  2   latched winner code for the winner screen
//  rgb              out  3   registered pixel colour to the DAC
//  screen           out  2   current screen: 00 START, 01 PLAY, 10 WINNER
// BEHAVIOUR
//  Reset (async, reset_n=0): screen=START, ce_start=1, other ce=0, rgb=000, winner_sel=00, rom_addr=0,
//   pending=none, frame counter=0, button sync regs=0. Leaving reset takes effect on the next clk edge.
//  start_btn: 2-FF synchroniser, then rising-edge detect -> 1-clk start_pulse. Held level is ignored.
//  frame_start: pixel_tick && pix_x==0 && pix_y==0. Only event on which screen changes.
//  FSM (next screen is registered in 'pending' and committed on frame_start):
//   START : start_pulse -> pending=PLAY.
//   PLAY  : game_over=1 -> pending=WINNER, winner_sel<=winner_in in the same clk (captured once;
//           later winner_in changes ignored). start_pulse is ignored in PLAY.
//   WINNER: frame counter clears on entry and increments on each frame_start, saturating at WIN_FRAMES.
//           start_pulse while count<WIN_FRAMES is discarded. Once count==WIN_FRAMES, start_pulse ->
//           pending=START. winner_sel clears to 00 when START is committed.
//  Simultaneous start_pulse and frame_start: the pulse is recorded in 'pending' and commits on the
//   next frame_start, one frame later. In PLAY, game_over and start_pulse together: game_over wins.
//  Only one pending transition: once pending is set, further events are ignored until commit.
//  Grant: rom_addr = address of the active screen, muxed combinationally from the registered screen.
//   ce_* are one-hot from screen and never change mid-frame.
//  rgb: on pixel_tick, rgb <= video_on ? active generator rgb : 000. Otherwise holds. Latency is one
//   pixel_tick from generator colour to rgb. The generator already absorbs the ROM read.
//  Out-of-range coordinates (pix_x>=H_ACTIVE or pix_y>=V_ACTIVE) produce rgb=000 regardless of video_on.
// STRUCTURE
//  Shared package/header tictactoe_defs: SCR_START/SCR_PLAY/SCR_WIN codes; WIN_NONE/X/O/DRAW codes;
//   colour constants BLACK..WHITE.
//  One natural sub-module: btn_sync_edge, containing the 2-FF synchroniser and rising-edge pulse.
//  FSM, frame counter, grant mux and rgb register stay in this module.
// TESTING
//  1 Reset mid-frame in WINNER: assert reset_n=0 -> screen=00, ce_start=1, rgb=000, winner_sel=00 immediately.
//  2 START, start_btn high for 5 clk mid-frame -> screen stays 00 until next (0,0) tick, then 01; exactly one
//    transition; rom_addr equals board_rom_addr afterwards.
//  3 PLAY, game_over=1 with winner_in=10, winner_in then changes to 01 -> winner_sel=10 held; screen=10 at next frame.
//  4 WINNER, start pulses at frames 10 and 179 -> both ignored; pulse at frame 181 -> START at following frame.
//  5 start_pulse on the same clk as frame_start in START -> PLAY commits one frame later, not immediately.
//  6 video_on=0 or pix_x=700 with board_rgb=111 -> rgb=000. video_on=1 -> rgb=111 one pixel_tick later.

Source files
------------

// File: rtl/screen_sequencer_pkg.sv
// Shared TicTacToe VGA definitions: screen codes, winner codes and 3-bit colours.
package screen_sequencer_pkg;

  typedef enum logic [1:0] {
    SCR_START = 2'b00,
    SCR_PLAY  = 2'b01,
    SCR_WIN   = 2'b10
  } scr_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

endpackage

// File: rtl/screen_sequencer_btn_sync_edge.sv
// Two-flop synchroniser for the raw start button followed by a rising-edge detector.
module screen_sequencer_btn_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic pulse
);

  logic sync_1, sync_2, sync_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= btn_raw;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign pulse = sync_2 & ~sync_prev;

endmodule

// File: rtl/screen_sequencer.sv
// Screen controller for the TicTacToe VGA path: START -> PLAY -> WINNER sequencing,
// font ROM grant, generator enables and the registered pixel colour.
//
//  state     | meaning
//  SCR_START | title screen, waiting for a start press
//  SCR_PLAY  | board screen, waiting for game_over
//  SCR_WIN   | winner screen, held at least WIN_FRAMES frames before a press returns to START
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int WIN_FRAMES = 180,
  parameter int FCNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pixel_tick,
  input  logic        video_on,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        start_btn,
  input  logic        game_over,
  input  logic [1:0]  winner_in,
  input  logic [10:0] start_rom_addr,
  input  logic [10:0] board_rom_addr,
  input  logic [10:0] win_rom_addr,
  input  logic [2:0]  start_rgb,
  input  logic [2:0]  board_rgb,
  input  logic [2:0]  win_rgb,
  output logic [10:0] rom_addr,
  output logic        ce_start,
  output logic        ce_board,
  output logic        ce_win,
  output logic [1:0]  winner_sel,
  output logic [2:0]  rgb,
  output logic [1:0]  screen
);

  localparam logic [9:0]        H_LIM   = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LIM   = 10'(V_ACTIVE);
  localparam logic [FCNT_W-1:0] WIN_CNT = FCNT_W'(WIN_FRAMES);

  logic start_pulse;
  logic frame_start;
  logic in_range;

  scr_t              screen_q, screen_d;
  scr_t              pend_scr_q, pend_scr_d;
  logic              pend_q, pend_d;
  logic [1:0]        win_q, win_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [2:0]        rgb_q, rgb_d;
  logic [2:0]        gen_rgb;
  logic [10:0]       addr_mux;

  screen_sequencer_btn_sync_edge u_btn (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (start_btn),
    .pulse   (start_pulse)
  );

  assign frame_start = pixel_tick && (pix_x == 10'd0) && (pix_y == 10'd0);
  assign in_range    = (pix_x < H_LIM) && (pix_y < V_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      screen_q   <= SCR_START;
      pend_scr_q <= SCR_START;
      pend_q     <= 1'b0;
      win_q      <= WIN_NONE;
      fcnt_q     <= '0;
      rgb_q      <= BLACK;
    end else begin
      screen_q   <= screen_d;
      pend_scr_q <= pend_scr_d;
      pend_q     <= pend_d;
      win_q      <= win_d;
      fcnt_q     <= fcnt_d;
      rgb_q      <= rgb_d;
    end
  end

  // Events are only taken while nothing is pending; the commit clock itself takes no new event.
  always_comb begin
    screen_d   = screen_q;
    pend_scr_d = pend_scr_q;
    pend_d     = pend_q;
    win_d      = win_q;
    fcnt_d     = fcnt_q;

    if (frame_start && screen_q == SCR_WIN && fcnt_q != WIN_CNT)
      fcnt_d = fcnt_q + 1'b1;

    if (pend_q) begin
      if (frame_start) begin
        screen_d = pend_scr_q;
        pend_d   = 1'b0;
        if (pend_scr_q == SCR_WIN)   fcnt_d = '0;
        if (pend_scr_q == SCR_START) win_d  = WIN_NONE;
      end
    end else begin
      case (screen_q)
        SCR_START: if (start_pulse) begin
          pend_d     = 1'b1;
          pend_scr_d = SCR_PLAY;
        end
        SCR_PLAY: if (game_over) begin
          pend_d     = 1'b1;
          pend_scr_d = SCR_WIN;
          win_d      = winner_in;
        end
        SCR_WIN: if (start_pulse && fcnt_q == WIN_CNT) begin
          pend_d     = 1'b1;
          pend_scr_d = SCR_START;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ce_start = 1'b0;
    ce_board = 1'b0;
    ce_win   = 1'b0;
    gen_rgb  = start_rgb;
    addr_mux = start_rom_addr;
    case (screen_q)
      SCR_PLAY: begin
        ce_board = 1'b1;
        gen_rgb  = board_rgb;
        addr_mux = board_rom_addr;
      end
      SCR_WIN: begin
        ce_win   = 1'b1;
        gen_rgb  = win_rgb;
        addr_mux = win_rom_addr;
      end
      default: ce_start = 1'b1;
    endcase
  end

  always_comb begin
    rgb_d = rgb_q;
    if (pixel_tick)
      rgb_d = (video_on && in_range) ? gen_rgb : BLACK;
  end

  // The grant reads as zero while reset is held so the ROM sees a known address.
  assign rom_addr   = reset_n ? addr_mux : 11'd0;
  assign winner_sel = win_q;
  assign rgb        = rgb_q;
  assign screen     = screen_q;

endmodule
